// File: rtl/muldiv_iter_pkg.sv
// muldiv_iter_pkg: op codes, FSM states and step modes shared by the iterative multiply/divide unit.
`default_nettype none

package muldiv_iter_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_iter_step.sv
// muldiv_step: one combinational iteration, either shift-add multiply or restoring-divide subtract.
`default_nettype none

module muldiv_step
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  step_mode_e         mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = '0;
        rem_sh   = '0;
        diff     = '0;
        acc_next = acc;
        if (mode == STEP_MUL) begin
            // {partial product, remaining multiplier bits}; carry lands in the top bit before the shift
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            // {remainder, dividend/quotient}; a clear borrow bit means the subtract is kept
            rem_sh = acc[2*WIDTH-1:WIDTH-1];
            diff   = rem_sh - {1'b0, operand};
            if (!diff[WIDTH])
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative MULT/MULTU/DIV/DIVU unit; WIDTH iterations, {hi,lo} result with done pulse.
`default_nettype none

module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    state_e             state, state_next;
    logic [CW-1:0]      count;
    step_mode_e         mode;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               launch;
    logic               last_iter;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign launch    = (state == ST_IDLE) && start && !cancel;
    assign last_iter = (state == ST_RUN) && !cancel && (count == CW'(WIDTH - 1));
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);

    always_comb begin
        sign_a = ((op == OP_MULT) || (op == OP_DIV)) && srca[WIDTH-1];
        sign_b = ((op == OP_MULT) || (op == OP_DIV)) && srcb[WIDTH-1];
        abs_a  = sign_a ? -srca : srca;
        abs_b  = sign_b ? -srcb : srcb;
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc),
        .operand (opnd),
        .mode    (mode),
        .acc_next(acc_step)
    );

    // Sign fix-up applied to the last iteration's accumulator as it is registered
    always_comb begin
        prod_fix = neg_q ? -acc_step : acc_step;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (mode == STEP_DIV) begin
            if (b_zero) begin
                res_hi = a_orig;
                res_lo = '1;
            end else begin
                res_lo = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
                res_hi = neg_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (launch) state_next = ST_RUN;
            ST_RUN: begin
                if (cancel)
                    state_next = ST_IDLE;
                else if (count == CW'(WIDTH - 1))
                    state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            mode    <= STEP_MUL;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            b_zero  <= 1'b0;
            opnd    <= '0;
            a_orig  <= '0;
            acc     <= '0;
            hi      <= '0;
            lo      <= '0;
            divzero <= 1'b0;
        end else begin
            if (launch) begin
                count  <= '0;
                mode   <= ((op == OP_DIV) || (op == OP_DIVU)) ? STEP_DIV : STEP_MUL;
                neg_q  <= sign_a ^ sign_b;
                neg_r  <= sign_a;
                b_zero <= (srcb == '0);
                opnd   <= abs_b;
                a_orig <= srca;
                acc    <= {{WIDTH{1'b0}}, abs_a};
            end else if (state == ST_RUN) begin
                acc   <= acc_step;
                count <= count + CW'(1);
            end
            if (last_iter) begin
                hi      <= res_hi;
                lo      <= res_lo;
                divzero <= (mode == STEP_DIV) && b_zero;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: randomized and directed self-checking bench for muldiv_iter against a plain-arithmetic model.
`default_nettype none

module tb_muldiv_iter;

    localparam int W     = 32;
    localparam int LIMIT = 200;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cancel;
    logic [1:0]   op;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divzero;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [64:0]  last_exp;

    always #5 clk = ~clk;

    muldiv_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cancel (cancel),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .divzero(divzero)
    );

    // Reference result {divzero, hi, lo} from 64-bit integer arithmetic
    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        longint      x, y, q, r;
        ea = (o[0] == 1'b0) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (o[0] == 1'b0) ? {{32{b[31]}}, b} : {32'b0, b};
        if (o[1] == 1'b0) begin
            p = ea * eb;
            return {1'b0, p};
        end
        if (b == 32'd0)
            return {1'b1, a, 32'hFFFF_FFFF};
        x = $signed(ea);
        y = $signed(eb);
        q = x / y;
        r = x % y;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Launch one op, scramble the operand inputs after the start edge, wait for done, then step back to IDLE
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [64:0] got, output int lat, output int busy_cycles);
        @(negedge clk);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        srca  = $urandom;
        srcb  = $urandom;
        op    = 2'($urandom);
        lat         = 0;
        busy_cycles = 0;
        while (!done && lat < LIMIT) begin
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        got = {divzero, hi, lo};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        srca   = '0;
        srcb   = '0;
        #23;
        n_checks++;
        if ({busy, done, divzero, hi, lo} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero", busy, done, divzero, hi, lo);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", busy, done);
        end
        last_exp = '0;
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [8];
        logic [31:0] t_a  [8];
        logic [31:0] t_b  [8];
        logic [64:0] t_e  [8];
        logic [64:0] got;
        int          lat, bc;
        t_op = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
        t_a  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000,
                 32'h7, 32'h7, 32'hFFFF_FFF9, 32'h8000_0000};
        t_b  = '{32'h5, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF,
                 32'h0, 32'h2, 32'h0, 32'h8000_0000};
        t_e  = '{{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1},
                 {1'b0, 32'hFFFF_FFFE, 32'h0000_0001},
                 {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
                 {1'b0, 32'h0000_0000, 32'h8000_0000},
                 {1'b1, 32'h0000_0007, 32'hFFFF_FFFF},
                 {1'b0, 32'h0000_0001, 32'h0000_0003},
                 {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF},
                 {1'b0, 32'h4000_0000, 32'h0000_0000}};
        for (int i = 0; i < 8; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], got, lat, bc);
            n_checks++;
            if (got !== t_e[i]) begin
                n_fail++;
                $display("FAIL directed_%0d result: got dz/hi/lo=%h, expected %h", i, got, t_e[i]);
            end
            // done rises in the cycle after edge WIDTH counted from the start edge
            n_checks++;
            if (lat != W) begin
                n_fail++;
                $display("FAIL directed_%0d latency: got %0d edges, expected %0d", i, lat, W);
            end
            n_checks++;
            if (bc != W) begin
                n_fail++;
                $display("FAIL directed_%0d busy_cycles: got %0d, expected %0d", i, bc, W);
            end
            n_checks++;
            if ({done, divzero, hi, lo} !== {1'b0, t_e[i]}) begin
                n_fail++;
                $display("FAIL directed_%0d held: got done=%b dz/hi/lo=%h, expected done=0 %h", i, done, {divzero, hi, lo}, t_e[i]);
            end
            last_exp = t_e[i];
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [64:0] got, expv;
        int          lat, bc;
        for (int i = 0; i < 40; i++) begin
            o    = 2'($urandom);
            a    = rand_operand();
            b    = rand_operand();
            expv = ref_model(o, a, b);
            run_op(o, a, b, got, lat, bc);
            n_checks++;
            if (got !== expv || lat != W) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %h lat=%0d, expected %h lat=%0d", i, o, a, b, got, lat, expv, W);
            end
            last_exp = expv;
        end
    endtask

    task automatic test_cancel();
        logic [64:0] got, expv;
        int          lat, bc, ndone;
        // cancel together with start in IDLE blocks the launch
        @(negedge clk);
        op = 2'b01; srca = 32'd9; srcb = 32'd9; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; cancel = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_idle: got busy=%b, expected 0", busy);
        end
        @(negedge clk);
        op = 2'b11; srca = 32'd1000; srcb = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_run_busy: got busy=%b, expected 0", busy);
        end
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_checks++;
        if (ndone != 0 || {divzero, hi, lo} !== last_exp) begin
            n_fail++;
            $display("FAIL cancel_run_outputs: got dones=%0d dz/hi/lo=%h, expected 0 %h", ndone, {divzero, hi, lo}, last_exp);
        end
        expv = ref_model(2'b10, 32'hFFFF_FC18, 32'd7);
        run_op(2'b10, 32'hFFFF_FC18, 32'd7, got, lat, bc);
        n_checks++;
        if (got !== expv || lat != W) begin
            n_fail++;
            $display("FAIL cancel_then_start: got %h lat=%0d, expected %h lat=%0d", got, lat, expv, W);
        end
        last_exp = expv;
    endtask

    task automatic test_start_while_busy();
        logic [64:0] got, expv;
        int          ndone;
        expv = ref_model(2'b00, 32'h1234_5678, 32'hFFFF_0001);
        @(negedge clk);
        op = 2'b00; srca = 32'h1234_5678; srcb = 32'hFFFF_0001; start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        got   = '0;
        for (int k = 1; k <= 60; k++) begin
            if (k < 20) begin
                op   = 2'($urandom);
                srca = $urandom;
                srcb = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                got = {divzero, hi, lo};
            end
        end
        n_checks++;
        if (ndone != 1 || got !== expv) begin
            n_fail++;
            $display("FAIL start_while_busy: got dones=%0d result=%h, expected 1 %h", ndone, got, expv);
        end
        last_exp = expv;
    endtask

    task automatic test_back_to_back();
        logic [64:0] expv;
        int          ndone, first_edge, second_edge;
        expv = ref_model(2'b11, 32'hDEAD_BEEF, 32'd13);
        @(negedge clk);
        op = 2'b11; srca = 32'hDEAD_BEEF; srcb = 32'd13; start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0; first_edge = -1; second_edge = -1;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first_edge < 0) first_edge = k;
                else second_edge = k;
                n_checks++;
                if ({divzero, hi, lo} !== expv) begin
                    n_fail++;
                    $display("FAIL back_to_back_result edge %0d: got %h, expected %h", k, {divzero, hi, lo}, expv);
                end
            end
        end
        start = 1'b0;
        // start held through DONE is ignored, so the next op begins WIDTH+2 edges after the first
        n_checks++;
        if (ndone != 2 || first_edge != W || second_edge != 2 * W + 2) begin
            n_fail++;
            $display("FAIL back_to_back_timing: got dones=%0d at %0d,%0d, expected 2 at %0d,%0d",
                     ndone, first_edge, second_edge, W, 2 * W + 2);
        end
        @(posedge clk);
        #1;
        last_exp = expv;
    endtask

    task automatic test_reset_mid();
        logic [64:0] got;
        int          lat, bc;
        run_op(2'b01, 32'd3, 32'd5, got, lat, bc);
        n_checks++;
        if (got !== 65'd15) begin
            n_fail++;
            $display("FAIL pre_reset_op: got %h, expected %h", got, 65'd15);
        end
        @(negedge clk);
        op = 2'b00; srca = 32'hFFFF_FFF0; srcb = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, divzero, hi, lo} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b done=%b dz=%b hi=%h lo=%h, expected all zero", busy, done, divzero, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_exp = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
